// File: rtl/run_ctrl_debounce.sv
// Front-panel control stage: synchronises and debounces the four panel
// buttons, turns debounced rising edges into single-cycle commands for the
// program counter, and tracks a run-status state for the panel LEDs.
module run_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_run,
  input  logic       btn_speed,
  input  logic       btn_halt,
  output logic       next_pulse,
  output logic       run_pulse,
  output logic       speedrun_pulse,
  output logic       halt_level,
  output logic [1:0] run_state
);

  // Button lanes: 0 = next, 1 = run, 2 = speed, 3 = halt
  localparam int NB = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FAST = 2'b10
  } state_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] s1;
  logic [NB-1:0] s2;
  logic [NB-1:0] db;
  logic [NB-1:0] db_nxt;
  logic [NB-1:0] rise;

  logic   next_cand;
  logic   run_cand;
  logic   speed_cand;
  logic   drop;
  state_t state;
  state_t state_nxt;

  assign raw = {btn_halt, btn_speed, btn_run, btn_next};

  // Two-flop synchroniser for every raw button; only s2 is consumed downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             lvl;
    logic             expire;

    assign expire    = (s2[i] != lvl) && (cnt == CNT_MAX);
    assign db[i]     = lvl;
    assign db_nxt[i] = expire ? s2[i] : lvl;
    assign rise[i]   = expire && s2[i];

    // Stability counter: any sample matching the current level restarts the count
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (s2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        lvl <= s2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Arbitrate candidates: halt (current or just rising) wins, then next > run > speed
  always_comb begin
    next_cand  = 1'b0;
    run_cand   = 1'b0;
    speed_cand = 1'b0;
    drop       = halt_level | rise[3];
    if (!drop) begin
      if (rise[0]) begin
        next_cand = 1'b1;
      end else if (rise[1]) begin
        run_cand = 1'b1;
      end else if (rise[2]) begin
        speed_cand = 1'b1;
      end
    end
  end

  // Registered command outputs and halt level, all with the same latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_pulse     <= 1'b0;
      run_pulse      <= 1'b0;
      speedrun_pulse <= 1'b0;
      halt_level     <= 1'b0;
    end else begin
      next_pulse     <= next_cand;
      run_pulse      <= run_cand;
      speedrun_pulse <= speed_cand;
      halt_level     <= db_nxt[3];
    end
  end

  // Run-status state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Run-status transitions driven by the arbitrated outputs; halt forces IDLE
  always_comb begin
    state_nxt = state;
    if (halt_level) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (run_pulse) begin
            state_nxt = RUN;
          end else if (speedrun_pulse) begin
            state_nxt = FAST;
          end
        end
        RUN: begin
          if (speedrun_pulse) begin
            state_nxt = FAST;
          end
        end
        FAST: begin
          if (run_pulse) begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign run_state = state;

endmodule

// File: tb/tb_run_ctrl_debounce.sv
// Directed bench for run_ctrl_debounce with a short debounce window (4 cycles).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_run_ctrl_debounce;

  logic       clk;
  logic       rst;
  logic       btn_next;
  logic       btn_run;
  logic       btn_speed;
  logic       btn_halt;
  logic       next_pulse;
  logic       run_pulse;
  logic       speedrun_pulse;
  logic       halt_level;
  logic [1:0] run_state;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n_next    = 0;
  int n_run     = 0;
  int n_speed   = 0;
  int multi_err = 0;
  int bad_state = 0;

  run_ctrl_debounce #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_next(btn_next),
    .btn_run(btn_run),
    .btn_speed(btn_speed),
    .btn_halt(btn_halt),
    .next_pulse(next_pulse),
    .run_pulse(run_pulse),
    .speedrun_pulse(speedrun_pulse),
    .halt_level(halt_level),
    .run_state(run_state)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then tally pulses and invariant violations
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (next_pulse === 1'b1) n_next++;
      if (run_pulse === 1'b1) n_run++;
      if (speedrun_pulse === 1'b1) n_speed++;
      if ((32'(next_pulse) + 32'(run_pulse) + 32'(speedrun_pulse)) > 1) multi_err++;
      if (run_state === 2'b11) bad_state++;
    end
  endtask

  task automatic clear_counts();
    n_next  = 0;
    n_run   = 0;
    n_speed = 0;
  endtask

  task automatic do_reset();
    btn_next  = 1'b0;
    btn_run   = 1'b0;
    btn_speed = 1'b0;
    btn_halt  = 1'b0;
    rst       = 1'b1;
    tick(2);
    rst = 1'b0;
    clear_counts();
  endtask

  task automatic test_reset();
    btn_next  = 1'b0;
    btn_run   = 1'b0;
    btn_speed = 1'b0;
    btn_halt  = 1'b0;
    rst       = 1'b1;
    tick(2);
    total_cnt++;
    if ({next_pulse, run_pulse, speedrun_pulse, halt_level} !== 4'b0000)
      $display("[TB] FAIL reset_outputs: got %b expected 0000", {next_pulse, run_pulse, speedrun_pulse, halt_level});
    else pass_cnt++;
    total_cnt++;
    if (run_state !== 2'b00) $display("[TB] FAIL reset_state: got %b expected 00", run_state);
    else pass_cnt++;
    rst = 1'b0;
    clear_counts();
  endtask

  task automatic test_run_single();
    do_reset();
    btn_run = 1'b1;
    tick(5);
    total_cnt++;
    if (n_run !== 0) $display("[TB] FAIL run_early: got %0d pulses expected 0", n_run);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (run_pulse !== 1'b1) $display("[TB] FAIL run_pulse_edge5: got %b expected 1", run_pulse);
    else pass_cnt++;
    total_cnt++;
    if (run_state !== 2'b00) $display("[TB] FAIL run_state_edge5: got %b expected 00", run_state);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if ({run_pulse, run_state} !== 3'b001)
      $display("[TB] FAIL run_state_edge6: got pulse,state %b expected 001", {run_pulse, run_state});
    else pass_cnt++;
    tick(100);
    total_cnt++;
    if (n_run !== 1) $display("[TB] FAIL run_hold_single: got %0d pulses expected 1", n_run);
    else pass_cnt++;
    btn_run = 1'b0;
    tick(12);
    total_cnt++;
    if ({n_run, n_next, n_speed} !== {32'd1, 32'd0, 32'd0})
      $display("[TB] FAIL run_release: got run=%0d next=%0d speed=%0d expected 1 0 0", n_run, n_next, n_speed);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    do_reset();
    pat = 6'b101101;
    for (int i = 5; i >= 0; i--) begin
      btn_next = pat[i];
      tick(1);
    end
    tick(4);
    total_cnt++;
    if (n_next !== 0) $display("[TB] FAIL bounce_early: got %0d pulses expected 0", n_next);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (next_pulse !== 1'b1) $display("[TB] FAIL bounce_pulse: got %b expected 1", next_pulse);
    else pass_cnt++;
    tick(20);
    total_cnt++;
    if (n_next !== 1) $display("[TB] FAIL bounce_single: got %0d pulses expected 1", n_next);
    else pass_cnt++;
    total_cnt++;
    if (run_state !== 2'b00) $display("[TB] FAIL next_no_state: got %b expected 00", run_state);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    btn_run   = 1'b1;
    btn_speed = 1'b1;
    tick(6);
    total_cnt++;
    if ({run_pulse, speedrun_pulse} !== 2'b10)
      $display("[TB] FAIL prio_run_speed: got run,speed %b expected 10", {run_pulse, speedrun_pulse});
    else pass_cnt++;
    tick(50);
    total_cnt++;
    if ({n_run, n_speed} !== {32'd1, 32'd0})
      $display("[TB] FAIL prio_no_late: got run=%0d speed=%0d expected 1 0", n_run, n_speed);
    else pass_cnt++;
    total_cnt++;
    if (run_state !== 2'b01) $display("[TB] FAIL prio_state: got %b expected 01", run_state);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    do_reset();
    btn_halt = 1'b1;
    tick(5);
    total_cnt++;
    if (halt_level !== 1'b0) $display("[TB] FAIL halt_early: got %b expected 0", halt_level);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (halt_level !== 1'b1) $display("[TB] FAIL halt_rise: got %b expected 1", halt_level);
    else pass_cnt++;
    btn_run = 1'b1;
    tick(20);
    total_cnt++;
    if ({n_run, run_state, halt_level} !== {32'd0, 2'b00, 1'b1})
      $display("[TB] FAIL halt_blocks_run: got run=%0d state=%b halt=%b expected 0 00 1", n_run, run_state, halt_level);
    else pass_cnt++;
    btn_halt = 1'b0;
    btn_run  = 1'b0;
    tick(12);
    total_cnt++;
    if (halt_level !== 1'b0) $display("[TB] FAIL halt_release: got %b expected 0", halt_level);
    else pass_cnt++;
    clear_counts();
    btn_run = 1'b1;
    tick(6);
    total_cnt++;
    if (run_pulse !== 1'b1) $display("[TB] FAIL run_after_halt: got %b expected 1", run_pulse);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (run_state !== 2'b01) $display("[TB] FAIL state_after_halt: got %b expected 01", run_state);
    else pass_cnt++;
  endtask

  task automatic test_speed_then_halt();
    btn_speed = 1'b1;
    tick(6);
    total_cnt++;
    if (speedrun_pulse !== 1'b1) $display("[TB] FAIL speed_pulse: got %b expected 1", speedrun_pulse);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (run_state !== 2'b10) $display("[TB] FAIL run_to_fast: got %b expected 10", run_state);
    else pass_cnt++;
    btn_halt = 1'b1;
    tick(6);
    total_cnt++;
    if ({halt_level, run_state} !== 3'b110)
      $display("[TB] FAIL halt_edge_state: got halt,state %b expected 110", {halt_level, run_state});
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (run_state !== 2'b00) $display("[TB] FAIL halt_to_idle: got %b expected 00", run_state);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_run = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({next_pulse, run_pulse, speedrun_pulse, halt_level, run_state} !== 6'b000000)
      $display("[TB] FAIL midreset_outputs: got %b expected 000000", {next_pulse, run_pulse, speedrun_pulse, halt_level, run_state});
    else pass_cnt++;
    tick(3);
    rst = 1'b0;
    clear_counts();
    tick(5);
    total_cnt++;
    if (n_run !== 0) $display("[TB] FAIL midreset_early: got %0d pulses expected 0", n_run);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (run_pulse !== 1'b1) $display("[TB] FAIL midreset_pulse: got %b expected 1", run_pulse);
    else pass_cnt++;
    tick(20);
    total_cnt++;
    if (n_run !== 1) $display("[TB] FAIL midreset_single: got %0d pulses expected 1", n_run);
    else pass_cnt++;
  endtask

  initial begin
    rst       = 1'b1;
    btn_next  = 1'b0;
    btn_run   = 1'b0;
    btn_speed = 1'b0;
    btn_halt  = 1'b0;
    test_reset();
    test_run_single();
    test_bounce();
    test_back_to_back();
    test_halt();
    test_speed_then_halt();
    test_reset_mid();
    total_cnt++;
    if (multi_err !== 0) $display("[TB] FAIL onehot_pulses: got %0d violations expected 0", multi_err);
    else pass_cnt++;
    total_cnt++;
    if (bad_state !== 0) $display("[TB] FAIL state_11: got %0d cycles expected 0", bad_state);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/run_ctrl_debounce.md
Name: run_ctrl_debounce

Overview:
- Front-panel control stage directly upstream of the program counter.
- Turns four raw, bouncing push-buttons (next, run, speedrun, halt) into clean synchronous commands for the counter: single-cycle NEXT/RUN/SPEEDRUN pulses and a debounced halt level driving the counter's ENABLE.
- Also keeps a run-status state machine for the panel LEDs.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable clocks needed before a debounced level changes (20 ms at 50 MHz); must be >= 2.
- CNT_W, 20, width of each per-button stability counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  reset; asynchronous, active-high.
- btn_next  input  1  raw single-step button; asynchronous, bouncing.
- btn_run  input  1  raw run button.
- btn_speed  input  1  raw speedrun button.
- btn_halt  input  1  raw halt button.
- next_pulse  output  1  one-cycle pulse, to counter NEXT.
- run_pulse  output  1  one-cycle pulse, to counter RUN.
- speedrun_pulse  output  1  one-cycle pulse, to counter SPEEDRUN.
- halt_level  output  1  debounced halt level, to counter ENABLE.
- run_state  output  2  status: 00 IDLE, 01 RUN, 10 FAST; 11 is never driven.

Behaviour:
- Reset (async, rst=1): all sync flops, debounced levels, counters and outputs go to 0; run_state = IDLE. Release takes effect at the next clk edge.
- Synchroniser:
  - Each button goes through its own 2-flop synchroniser (s1, s2).
  - No logic reads s1 or the raw input.
- Debounce, per button (level db, counter cnt):
  - If s2 == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch back to db restarts the count from 0.
- Latency: raw level first sampled at edge 0 -> s2 valid after edge 1 -> db changes at edge DEBOUNCE_CYCLES+1.
- Command pulses:
  - A candidate pulse for next/run/speed is raised in the same edge where that button's db goes 0->1.
  - Outputs are registered and high for exactly one clk cycle.
  - A button cannot pulse again until db has returned to 0 and risen again; holding a button gives exactly one pulse.
  - The 1->0 transition of db produces no pulse.
- Arbitration:
  - While halt_level = 1 (including the edge where halt db rises), all candidate pulses are dropped, not queued.
  - Otherwise, if several candidates fall in the same cycle, priority is next > run > speed. Losers are dropped, and their db still updates so they will not fire later.
  - At most one of the three pulse outputs is high in any cycle.
- halt_level equals debounced halt db, registered, with the same latency as the pulses.
- run_state FSM, evaluated on the arbitrated outputs:
  - IDLE -> RUN on run_pulse; IDLE -> FAST on speedrun_pulse.
  - RUN -> FAST on speedrun_pulse; FAST -> RUN on run_pulse.
  - Any state -> IDLE in the cycle after halt_level is 1.
  - next_pulse does not change state.
- Reset mid-debounce: counts are discarded; a button still held after reset is treated as a fresh press and pulses after the full latency.

Test Plan:
- DEBOUNCE_CYCLES=4, clean btn_run rise sampled at edge 0 and held -> run_pulse high for one cycle after edge 5; run_state 00->01 at edge 6; no further pulse while held 100 cycles.
- btn_next bouncing 1,0,1,1,0,1 (one clock each), then held -> no pulse during bounce; one next_pulse exactly 5 edges after the last 0->1 sample.
- btn_run and btn_speed rise on the same clock -> only run_pulse fires; speedrun_pulse stays 0; no late speedrun pulse after 50 cycles.
- btn_halt held, then btn_run pressed -> halt_level = 1, run_pulse never asserts, run_state stays 00. Release halt, re-press run -> run_pulse fires.
- In RUN, press btn_speed -> run_state 01->10. Press halt -> halt_level 1 and run_state 00 the next cycle.
- Assert rst for 3 cycles with btn_run held and cnt = 2 -> all outputs 0. After release, one run_pulse at edge 5 relative to first post-reset sample.
